// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 16/32-bit instructions halfword by halfword from
// instruction memory and presents them to the decoder with a valid/ready
// handshake. A redirect from execute overrides everything and costs one
// idle bubble cycle.
// Optional build macro FETCH_SEQ_PERF_EN adds retired/stall counters.
module fetch_sequencer #(
    parameter int                   PC_WIDTH = 24,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_data,
    input  logic                branch_valid,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr_word,
    output logic                instr_is32,
    output logic [PC_WIDTH-1:0] instr_pc
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]         perf_instr_count,
    output logic [31:0]         perf_stall_count
`endif
);

    typedef enum logic [1:0] {
        FETCH_LO,
        FETCH_HI,
        HOLD,
        REDIRECT
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_word_q, instr_word_d;
    logic                instr_is32_q, instr_is32_d;
    logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;

    // Next-state logic: a redirect wins over any same-cycle ack or handshake.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_word_d = instr_word_q;
        instr_is32_d = instr_is32_q;
        instr_pc_d   = instr_pc_q;

        unique case (state_q)
            FETCH_LO: begin
                if (imem_ack) begin
                    instr_word_d = {16'h0000, imem_data};
                    instr_pc_d   = pc_q;
                    instr_is32_d = 1'b0;
                    pc_d         = pc_q + PC_ONE;
                    state_d      = imem_data[15] ? FETCH_HI : HOLD;
                end
            end
            FETCH_HI: begin
                if (imem_ack) begin
                    instr_word_d = {imem_data, instr_word_q[15:0]};
                    instr_is32_d = 1'b1;
                    pc_d         = pc_q + PC_ONE;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    state_d = FETCH_LO;
                end
            end
            REDIRECT: begin
                state_d = FETCH_LO;
            end
            default: begin
                state_d = FETCH_LO;
            end
        endcase

        if (branch_valid) begin
            instr_word_d = instr_word_q;
            instr_is32_d = instr_is32_q;
            instr_pc_d   = instr_pc_q;
            pc_d         = branch_target;
            state_d      = REDIRECT;
        end
    end

    // State, program counter and presented-instruction registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH_LO;
            pc_q         <= RESET_PC;
            instr_word_q <= '0;
            instr_is32_q <= 1'b0;
            instr_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_word_q <= instr_word_d;
            instr_is32_q <= instr_is32_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

    // Outputs depend only on state, so the address is stable while waiting for ack.
    always_comb begin
        imem_req    = (state_q == FETCH_LO) || (state_q == FETCH_HI);
        imem_addr   = pc_q;
        instr_valid = (state_q == HOLD);
        instr_word  = instr_word_q;
        instr_is32  = instr_is32_q;
        instr_pc    = instr_pc_q;
    end

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_instr_count_q, perf_instr_count_d;
    logic [31:0] perf_stall_count_q, perf_stall_count_d;

    // Count accepted instructions and cycles where the decoder back-pressures.
    always_comb begin
        perf_instr_count_d = perf_instr_count_q;
        perf_stall_count_d = perf_stall_count_q;
        if (instr_valid && instr_ready) begin
            perf_instr_count_d = perf_instr_count_q + 32'd1;
        end
        if (instr_valid && !instr_ready) begin
            perf_stall_count_d = perf_stall_count_q + 32'd1;
        end
    end

    // Counter registers, free-running and wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_instr_count_q <= '0;
            perf_stall_count_q <= '0;
        end else begin
            perf_instr_count_q <= perf_instr_count_d;
            perf_stall_count_q <= perf_stall_count_d;
        end
    end

    assign perf_instr_count = perf_instr_count_q;
    assign perf_stall_count = perf_stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by a randomized
// run, all checked against an instruction-stream reference model.
module tb_fetch_sequencer;

    localparam int PC_WIDTH = 24;
    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;
    typedef logic [PC_WIDTH-1:0] addr_t;

    logic        clock;
    logic        reset;
    logic        imem_req;
    addr_t       imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        branch_valid;
    addr_t       branch_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic        instr_is32;
    addr_t       instr_pc;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_instr_count;
    logic [31:0] perf_stall_count;
`endif

    int checks = 0;
    int errors = 0;

    // Memory image: explicit overrides, otherwise a fixed hash of the address.
    logic [15:0] mem_ovr [int];

    // Reference model: start address of the instruction in flight, halfwords
    // received so far, redirect bubble pending, expected counter values.
    addr_t       m_start;
    int          m_k;
    bit          m_bubble;
    logic [31:0] m_perf_instr;
    logic [31:0] m_perf_stall;

    fetch_sequencer #(
        .PC_WIDTH(PC_WIDTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_data(imem_data),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_word(instr_word),
        .instr_is32(instr_is32),
        .instr_pc(instr_pc)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .perf_instr_count(perf_instr_count),
        .perf_stall_count(perf_stall_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] mem_read(input addr_t a);
        logic [31:0] h;
        if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
        h = {8'h00, a} * 32'h9E3779B1;
        h = h ^ (h >> 15);
        return h[23:8];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        m_start      = RESET_PC;
        m_k          = 0;
        m_bubble     = 1'b0;
        m_perf_instr = '0;
        m_perf_stall = '0;
    endtask

    task automatic drive_idle();
        imem_ack      = 1'b0;
        imem_data     = '0;
        branch_valid  = 1'b0;
        branch_target = '0;
        instr_ready   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(instr_valid), 64'(0));
        check({tag, "_word"}, 64'(instr_word), 64'(0));
        check({tag, "_is32"}, 64'(instr_is32), 64'(0));
        check({tag, "_pc"}, 64'(instr_pc), 64'(0));
    endtask

    // Synchronous-looking reset sequence; leaves us at a negedge with reset released.
    task automatic apply_reset();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_values("rst");
        reset = 1'b0;
        model_init();
    endtask

    // Reset raised between clock edges must clear the presented instruction at once.
    task automatic async_reset_pulse(input string tag);
        drive_idle();
        #2 reset = 1'b1;
        #1 check_reset_values(tag);
        @(negedge clock);
        reset = 1'b0;
        model_init();
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic do_cycle(input bit ack, input bit ready, input bit br, input addr_t tgt);
        logic [15:0] w0;
        logic [15:0] w1;
        bit          is32;
        int          len;
        bit          exp_req;
        bit          exp_valid;
        addr_t       a_exp;
        w0        = mem_read(m_start);
        is32      = w0[15];
        w1        = is32 ? mem_read(m_start + addr_t'(1)) : 16'h0000;
        len       = is32 ? 2 : 1;
        exp_req   = !m_bubble && (m_k < len);
        exp_valid = !m_bubble && (m_k == len);
        a_exp     = m_start + addr_t'(m_k);

        check("imem_req", 64'(imem_req), 64'(exp_req));
        check("instr_valid", 64'(instr_valid), 64'(exp_valid));
        if (exp_req) check("imem_addr", 64'(imem_addr), 64'(a_exp));
        if (exp_valid) begin
            check("instr_word", 64'(instr_word), 64'({w1, w0}));
            check("instr_is32", 64'(instr_is32), 64'(is32));
            check("instr_pc", 64'(instr_pc), 64'(m_start));
        end
`ifdef FETCH_SEQ_PERF_EN
        check("perf_instr", 64'(perf_instr_count), 64'(m_perf_instr));
        check("perf_stall", 64'(perf_stall_count), 64'(m_perf_stall));
`endif

        imem_ack      = ack;
        imem_data     = ack ? mem_read(imem_addr) : 16'($urandom);
        branch_valid  = br;
        branch_target = tgt;
        instr_ready   = ready;

        if (exp_valid) begin
            if (ready) m_perf_instr = m_perf_instr + 32'd1;
            else       m_perf_stall = m_perf_stall + 32'd1;
        end
        if (br) begin
            m_start  = tgt;
            m_k      = 0;
            m_bubble = 1'b1;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else if (exp_req && ack) begin
            m_k++;
        end else if (exp_valid && ready) begin
            m_start = m_start + addr_t'(len);
            m_k     = 0;
        end
        @(negedge clock);
    endtask

    initial begin
        bit    r_ack;
        bit    r_ready;
        bit    r_br;
        addr_t r_tgt;
        reset = 1'b1;
        drive_idle();
        model_init();

        // Three consecutive 16-bit instructions, memory always acks, decoder always ready.
        mem_ovr[0] = 16'd522;
        mem_ovr[1] = 16'd578;
        mem_ovr[2] = 16'd1218;
        apply_reset();
        check("first_req", 64'(imem_req), 64'(1));
        check("first_addr", 64'(imem_addr), 64'(RESET_PC));
        repeat (6) do_cycle(1'b1, 1'b1, 1'b0, '0);

        // A 32-bit instruction split across addresses 0 and 1.
        mem_ovr.delete();
        mem_ovr[0] = 16'h8A00;
        mem_ovr[1] = 16'h1234;
        apply_reset();
        do_cycle(1'b1, 1'b0, 1'b0, '0);
        do_cycle(1'b1, 1'b0, 1'b0, '0);
        check("w32_word", 64'(instr_word), 64'(32'h12348A00));
        check("w32_is32", 64'(instr_is32), 64'(1));
        check("w32_pc", 64'(instr_pc), 64'(0));

        // Decoder stalls five cycles, then accepts; next fetch is at address 2.
        repeat (5) do_cycle(1'b0, 1'b0, 1'b0, '0);
        do_cycle(1'b0, 1'b1, 1'b0, '0);
`ifdef FETCH_SEQ_PERF_EN
        check("stall_5", 64'(perf_stall_count), 64'(5));
        check("instr_1", 64'(perf_instr_count), 64'(1));
`endif
        check("next_addr", 64'(imem_addr), 64'(2));

        // Redirect coinciding with the second-halfword ack.
        mem_ovr[2] = 16'h9000;
        do_cycle(1'b1, 1'b0, 1'b0, '0);
        do_cycle(1'b1, 1'b0, 1'b1, addr_t'(24'h000100));
        check("bubble_req", 64'(imem_req), 64'(0));
        check("bubble_valid", 64'(instr_valid), 64'(0));
        do_cycle(1'b0, 1'b0, 1'b0, '0);
        check("redir_req", 64'(imem_req), 64'(1));
        check("redir_addr", 64'(imem_addr), 64'(24'h000100));

        // 32-bit instruction at the top of the address space wraps to 0.
        mem_ovr[24'hFFFFFF] = 16'h8001;
        do_cycle(1'b0, 1'b0, 1'b1, addr_t'(24'hFFFFFF));
        do_cycle(1'b0, 1'b0, 1'b0, '0);
        do_cycle(1'b1, 1'b0, 1'b0, '0);
        check("wrap_addr", 64'(imem_addr), 64'(0));
        do_cycle(1'b1, 1'b0, 1'b0, '0);
        check("wrap_pc", 64'(instr_pc), 64'(24'hFFFFFF));
        check("wrap_is32", 64'(instr_is32), 64'(1));
        check("wrap_word", 64'(instr_word), 64'(32'h8A008001));

        // Branch and handshake in the same HOLD cycle.
        do_cycle(1'b0, 1'b1, 1'b1, addr_t'(24'h000040));
        do_cycle(1'b0, 1'b0, 1'b0, '0);

        // Reset while presenting an instruction, then while awaiting an ack.
        mem_ovr[24'h000040] = 16'h0055;
        do_cycle(1'b1, 1'b0, 1'b0, '0);
        check("pre_rst_valid", 64'(instr_valid), 64'(1));
        async_reset_pulse("rst_hold");
        do_cycle(1'b0, 1'b0, 1'b0, '0);
        async_reset_pulse("rst_fetch");
        check("post_rst_addr", 64'(imem_addr), 64'(RESET_PC));
        check("post_rst_req", 64'(imem_req), 64'(1));

        // Randomized traffic including spurious acks and redirects near the wrap point.
        mem_ovr.delete();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            r_ack   = ($urandom_range(0, 99) < 60);
            r_ready = ($urandom_range(0, 99) < 60);
            r_br    = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) r_tgt = addr_t'(24'hFFFFFF) - addr_t'($urandom_range(0, 3));
            else                           r_tgt = addr_t'($urandom);
            do_cycle(r_ack, r_ready, r_br, r_tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
